// File: rtl/uart_pkg.sv
// Shared UART definitions: default data width, the received-frame record,
// and a saturating increment used by the error-drop counter.
package uart_pkg;

    localparam int UART_DATA_W = 7;
    localparam int DROP_CNT_W  = 8;

    // Received frame as produced by the receiver; status flags sit above data.
    typedef struct packed {
        logic                   parity_err;
        logic                   framing_err;
        logic [UART_DATA_W-1:0] data;
    } rx_frame_t;

    // Saturating +1 for the drop counter (sticks at all-ones).
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rx_fifo_mem.sv
// Frame storage for rx_frame_fifo: one synchronous write port and an
// asynchronous read of the head address, so the FIFO can fall through.
module rx_fifo_mem #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 9,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Entry write; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/rx_frame_fifo.sv
// Receive frame FIFO, first-word-fall-through, with sticky overflow.
// Optional feature: define RX_FIFO_DROP_ERR_EN to discard frames carrying a
// parity or framing error (counted in drop_count) instead of storing them.
module rx_frame_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = UART_DATA_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_stb,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     wr_parity_err,
    input  logic                     wr_framing_err,
    input  logic                     rd_pop,
    output logic                     rd_valid,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     rd_parity_err,
    output logic                     rd_framing_err,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    input  logic                     clear_ovf,
    output logic [DROP_CNT_W-1:0]    drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Same field order as uart_pkg::rx_frame_t, sized by DATA_WIDTH.
    typedef struct packed {
        logic                  parity_err;
        logic                  framing_err;
        logic [DATA_WIDTH-1:0] data;
    } frame_t;

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt;
    logic          ovf;
    logic          do_pop, do_wr, wr_try, ovf_set, err_drop;
    frame_t        wr_frame, head;

    assign empty  = (cnt == '0);
    assign full   = (cnt == CW'(DEPTH));
    assign do_pop = rd_pop & ~empty;

`ifdef RX_FIFO_DROP_ERR_EN
    assign err_drop = wr_stb & (wr_parity_err | wr_framing_err);
`else
    assign err_drop = 1'b0;
`endif

    // A write while full is only accepted if a pop frees the slot this edge.
    assign wr_try  = wr_stb & ~err_drop;
    assign do_wr   = wr_try & (~full | do_pop);
    assign ovf_set = wr_try & full & ~do_pop;

    assign wr_frame = '{parity_err: wr_parity_err, framing_err: wr_framing_err, data: wr_data};

    rx_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(frame_t))
    ) u_mem (
        .clk     (clk),
        .wr_en   (do_wr & ~reset),
        .wr_addr (wr_ptr),
        .wr_data (wr_frame),
        .rd_addr (rd_ptr),
        .rd_data (head)
    );

    // Pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr)  wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Sticky overflow; a lost frame on the same edge beats the clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          ovf <= 1'b0;
        else if (ovf_set)   ovf <= 1'b1;
        else if (clear_ovf) ovf <= 1'b0;
    end

`ifdef RX_FIFO_DROP_ERR_EN
    logic [DROP_CNT_W-1:0] drops;

    // Count discarded errored frames, saturating.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         drops <= '0;
        else if (err_drop) drops <= sat_inc(drops);
    end

    assign drop_count = drops;
`else
    assign drop_count = '0;
`endif

    // Head is only meaningful when valid; show zeros otherwise.
    assign rd_valid       = ~empty;
    assign rd_data        = rd_valid ? head.data        : '0;
    assign rd_parity_err  = rd_valid ? head.parity_err  : 1'b0;
    assign rd_framing_err = rd_valid ? head.framing_err : 1'b0;
    assign count          = cnt;
    assign overflow       = ovf;

endmodule

// File: doc/rx_frame_fifo.md
RX_FRAME_FIFO -- requirements
Module: rx_frame_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of frame entries; power of two, 2..256.
REQ-002 SHALL have parameter DATA_WIDTH, default 7, data bits per frame.
REQ-003 SHALL have port clk  input  1  system clock; one clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port wr_stb  input  1  one-cycle frame-received pulse from receiver load.
REQ-006 SHALL have port wr_data  input  DATA_WIDTH  received data bits.
REQ-007 SHALL have port wr_parity_err  input  1  parity error of incoming frame.
REQ-008 SHALL have port wr_framing_err  input  1  framing error of incoming frame.
REQ-009 SHALL have port rd_pop  input  1  consumer acknowledge of head entry.
REQ-010 SHALL have port rd_valid  output  1  head entry present.
REQ-011 SHALL have port rd_data  output  DATA_WIDTH  head entry data.
REQ-012 SHALL have port rd_parity_err  output  1  head entry parity flag.
REQ-013 SHALL have port rd_framing_err  output  1  head entry framing flag.
REQ-014 SHALL have port count  output  log2(DEPTH)+1  occupied entries.
REQ-015 SHALL have ports full and empty  output  1 each  occupancy status, combinational from count.
REQ-016 SHALL have port overflow  output  1  sticky lost-frame flag.
REQ-017 SHALL have port clear_ovf  input  1  clears overflow.
REQ-018 SHALL have port drop_count  output  8  errored frames discarded (see Configuration).

Function
REQ-019 SHALL be first-word-fall-through: rd_data/flags show head entry whenever rd_valid=1; rd_valid = !empty.
REQ-020 SHALL write entry on rising edge where wr_stb=1 and not full; visible at head (if FIFO was empty) in cycle after that edge.
REQ-021 SHALL pop on edge where rd_pop=1 and rd_valid=1; rd_pop while empty SHALL be ignored, no state change.
REQ-022 SHALL, on wr_stb while full and no pop, discard frame, leave count=DEPTH, set overflow.
REQ-023 SHALL, on wr_stb and valid pop same edge while full, accept both; count stays DEPTH, overflow unchanged.
REQ-024 SHALL, on wr_stb and rd_pop same edge while empty, accept write, ignore pop; count becomes 1.
REQ-025 SHALL wrap read/write pointers modulo DEPTH; count = writes accepted - pops accepted, never exceeding DEPTH.
REQ-026 SHALL clear overflow on clear_ovf=1; if overflow set condition occurs same edge, set SHALL win.
REQ-027 SHALL treat a wr_stb held high multiple cycles as one write per cycle.

Reset
REQ-028 SHALL on reset: pointers 0, count 0, empty 1, full 0, rd_valid 0, overflow 0, drop_count 0; rd_data and flags 0.
REQ-029 SHALL, on reset asserted mid-operation, discard all stored entries immediately; no pop or write completes on that edge.

Configuration
REQ-030 SHALL honour macro RX_FIFO_DROP_ERR_EN: when defined, frames with wr_parity_err or wr_framing_err =1 SHALL NOT be stored and drop_count SHALL increment, saturating at 255; drop does not set overflow.
REQ-031 SHALL, without RX_FIFO_DROP_ERR_EN, store errored frames with their flags and hold drop_count at 0.

Structure
REQ-032 SHALL take DATA_WIDTH default and the frame typedef {parity_err, framing_err, data} from shared package uart_pkg.
REQ-033 SHALL place storage array in sub-module rx_fifo_mem (one write port, asynchronous read of head address).

Verification
REQ-034 SHALL cover: reset, write 0x41 flags 0 -> next cycle rd_valid=1, rd_data=0x41, count=1.
REQ-035 SHALL cover: 9 writes 0x30..0x38 with DEPTH=8, no pops -> count=8, full=1, overflow=1, pops return 0x30..0x37 in order.
REQ-036 SHALL cover: full FIFO, wr_stb 0x55 plus rd_pop same edge -> count=8, overflow=0, 0x55 read last.
REQ-037 SHALL cover: empty FIFO, wr_stb 0x12 plus rd_pop same edge -> count=1, head 0x12.
REQ-038 SHALL cover: write 0x7F with wr_parity_err=1 -> with macro: empty stays 1, drop_count=1; without: rd_parity_err=1, rd_data=0x7F.
REQ-039 SHALL cover: 5 entries then reset pulse mid-cycle -> count=0, empty=1, overflow=0 asynchronously.
